// File: rtl/rob_pkg.sv
// Shared definitions for the multi-channel reorder buffer: default widths,
// slot layout and the tag arithmetic used by rob_mc.
package rob_pkg;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_DATA_W    = 512;
    localparam int DEF_TAG_W     = 10;
    localparam int DEF_RID_W     = 16;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_FIRST_TAG = 1;

    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] data;
    } rob_slot_t;

    // DEPTH is a power of two, so the slot index is the low tag bits.
    function automatic int unsigned tag_to_idx(input logic [31:0] tag,
                                               input int unsigned depth);
        return tag & (depth - 1);
    endfunction

    // Distance from head to tag, taken modulo 2^tag_w, must fit in the buffer.
    function automatic logic in_window(input logic [31:0] tag,
                                       input logic [31:0] head,
                                       input int unsigned tag_w,
                                       input int unsigned depth);
        logic [31:0] mask;
        mask = (32'd1 << tag_w) - 32'd1;
        return ((tag - head) & mask) < depth;
    endfunction

endpackage

// File: rtl/rob_out_stage.sv
// Single-entry valid/ready output register of the reorder buffer.
// A beat transfers on a rising edge where valid_o && ready_i; once valid_o is
// raised, valid_o, rid_o and rdata_o hold unchanged until that transfer.
module rob_out_stage #(
    parameter int RID_W  = 16,
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [RID_W-1:0]  ld_rid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              free,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [RID_W-1:0]  rid_o,
    output logic [DATA_W-1:0] rdata_o
);

    assign free = !valid_o || ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            rid_o   <= '0;
            rdata_o <= '0;
        end else if (free) begin
            valid_o <= load;
            if (load) begin
                rid_o   <= ld_rid;
                rdata_o <= ld_data;
            end
        end
    end

endmodule

// File: rtl/rob_mc.sv
// Multi-channel reorder buffer: tagged writes on NUM_CH channels, in-order
// release on one valid/ready port. Optional write checking: ROB_ERR_CHECK_EN.
module rob_mc
    import rob_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int RID_W     = DEF_RID_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FIRST_TAG = DEF_FIRST_TAG
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CH-1:0]                write_en_i,
    input  logic [NUM_CH*(TAG_W+DATA_W)-1:0] wdata_i,
    output logic [NUM_CH-1:0]                full_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [RID_W-1:0]                 rid_o,
    output logic [DATA_W-1:0]                rdata_o,
    output logic                             err_o
);

    localparam int W     = TAG_W + DATA_W;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Same layout as rob_slot_t, sized to this instance's data width.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t             slots [DEPTH];
    logic [TAG_W-1:0]  head;
    logic [IDX_W-1:0]  head_idx;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  n_win;

    logic [TAG_W-1:0]  wr_tag  [NUM_CH];
    logic [DATA_W-1:0] wr_data [NUM_CH];
    logic [IDX_W-1:0]  wr_idx  [NUM_CH];
    logic [NUM_CH-1:0] wr_ok;
    logic [NUM_CH-1:0] wr_win;

    logic              out_free;
    logic              drain;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_tag[c]  = wdata_i[c*W+DATA_W +: TAG_W];
            wr_data[c] = wdata_i[c*W +: DATA_W];
            wr_idx[c]  = IDX_W'(tag_to_idx(32'(wr_tag[c]), DEPTH));
        end
    end

    // Per-channel legality, then lowest channel wins on a shared slot.
    always_comb begin
        wr_ok  = '0;
        wr_win = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ok[c] = write_en_i[c] && !full_o[c];
`ifdef ROB_ERR_CHECK_EN
            wr_ok[c] = wr_ok[c]
                     && in_window(32'(wr_tag[c]), 32'(head), TAG_W, DEPTH)
                     && !slots[wr_idx[c]].valid;
`endif
            wr_win[c] = wr_ok[c];
            for (int l = 0; l < c; l++) begin
                if (wr_ok[l] && (wr_idx[l] == wr_idx[c])) begin
                    wr_win[c] = 1'b0;
                end
            end
        end
    end

    assign head_idx = IDX_W'(tag_to_idx(32'(head), DEPTH));
    assign drain    = slots[head_idx].valid && out_free;

    always_comb begin
        n_win = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            n_win = n_win + CNT_W'(wr_win[c]);
        end
        count_next = count + n_win - CNT_W'(drain);
    end

    // The in-window rule keeps writes off the head slot while it drains,
    // so clear-then-set ordering never discards a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < DEPTH; d++) begin
                slots[d] <= '0;
            end
            head   <= TAG_W'(FIRST_TAG);
            count  <= '0;
            full_o <= '0;
        end else begin
            if (drain) begin
                slots[head_idx].valid <= 1'b0;
                head                  <= head + TAG_W'(1);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_win[c]) begin
                    slots[wr_idx[c]] <= '{valid: 1'b1, data: wr_data[c]};
                end
            end
            count <= count_next;
            // Channel c stalls early enough that channels 0..c together still fit.
            for (int c = 0; c < NUM_CH; c++) begin
                full_o[c] <= (CNT_W'(DEPTH) - count_next) <= CNT_W'(c);
            end
        end
    end

`ifdef ROB_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (|(write_en_i & ~wr_win)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    rob_out_stage #(
        .RID_W  (RID_W),
        .DATA_W (DATA_W)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (drain),
        .ld_rid  (RID_W'(head)),
        .ld_data (slots[head_idx].data),
        .free    (out_free),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .rid_o   (rid_o),
        .rdata_o (rdata_o)
    );

endmodule
